if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 73 +++++++
 tb/tb_if_id_buffer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Two-entry in-order skid buffer between fetch and decode, holding {pc, instr} per entry.
// Handshake outputs come only from registered occupancy, so in_ready never depends on out_ready.
module if_id_buffer #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready,
    output logic [1:0]      count
);

    logic [XLEN-1:0] pc_mem    [2];
    logic [XLEN-1:0] instr_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      occ;
    logic            push;
    logic            pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign count     = occ;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Payload needs no reset: the output mux below hides entries outside the valid window.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus queues accepted words, a negedge monitor checks outputs.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [1:0]  count;

    word_t exp_q[$];
    int    st_cnt = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    if_id_buffer #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return 32'hA500_0000 ^ (pc << 4) ^ pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge; record the expected push after the next edge.
    task automatic step(input bit v, input logic [31:0] pc, input bit ordy, input bit fl);
        bit push, pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = ordy;
        flush     = fl;
        push = v && (st_cnt != 2) && !fl;
        pop  = (st_cnt != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) st_cnt = 0;
        else    st_cnt = st_cnt + int'(push) - int'(pop);
        if (push) exp_q.push_back('{pc: pc, instr: mk_instr(pc)});
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
            if (exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", out_instr, exp_q[0].instr);
            end else begin
                check("empty_pc", out_pc, 32'h0);
                check("empty_instr", out_instr, NOP);
            end
            if (flush) exp_q.delete();
            else if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] pc_seq;
        bit v, r, f;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_instr", out_instr, NOP);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Fill: A then B, third word C must be refused while full.
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        // Drain A then B, then empty.
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // Pass-through at occupancy 1.
        step(1, 32'h0C, 0, 0);
        for (int unsigned i = 0; i < 4; i++) step(1, 32'h10 + 4 * i, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0);

        // Flush from full with an in-flight word D, then refill after flush.
        step(1, 32'h30, 0, 0);
        step(1, 32'h34, 0, 0);
        step(1, 32'h40, 1, 1);
        step(1, 32'h44, 0, 0);
        step(1, 32'h48, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // Asynchronous reset while full.
        step(1, 32'h50, 0, 0);
        step(1, 32'h54, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        exp_q.delete();
        st_cnt = 0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_instr", out_instr, NOP);
        check("arst_count", 32'(count), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1, 32'h60, 0, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0);

        // Randomised traffic against the same scoreboard.
        pc_seq = 32'h1000;
        for (int unsigned i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 19) == 0);
            step(v, pc_seq, r, f);
            if (v) pc_seq = pc_seq + 32'h4;
        end
        for (int unsigned i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
        @(negedge clk); #1;
        check("final_empty", 32'(exp_q.size()), 32'h0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
